// File: rtl/max_tree_argmax.sv
// max_tree_argmax: pipelined argmax tree over N_CH values, one comparison level per register stage.
// Optional MAX_TREE_THRESH_EN adds threshold_i/above_o, carried alongside each sample set.
module max_tree_argmax #(
    parameter int N_CH = 7,
    parameter int WIDTH = 16,
    parameter int SIGNED = 0,
    localparam int IDX_W = N_CH > 1 ? $clog2(N_CH) : 1,
    localparam int LEVELS = IDX_W
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i [N_CH-1:0],
    output logic             valid_o,
    input  logic             ready_i,
    output logic [IDX_W-1:0] index_o,
    output logic [WIDTH-1:0] max_o
`ifdef MAX_TREE_THRESH_EN
    ,
    output logic             above_o,
    input  logic [WIDTH-1:0] threshold_i
`endif
);
    function automatic int cnt(input int k);
        int n = N_CH;
        for (int l = 0; l < k; l++) n = (n + 1) / 2;
        return n;
    endfunction

    function automatic logic ge(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (SIGNED != 0) ? ($signed(a) >= $signed(b)) : (a >= b);
    endfunction

    assign ready_o = ~(valid_o & ~ready_i);

    // stg[0] is the combinational view of the inputs; stg[k] holds tree level k
    for (genvar k = 0; k <= LEVELS; k++) begin : stg
        localparam int N = cnt(k);
        logic [WIDTH-1:0] v [N-1:0];
        logic [IDX_W-1:0] i [N-1:0];
        logic             vld;
        if (k == 0) begin : in
            assign vld = valid_i;
            assign v = data_i;
            for (genvar j = 0; j < N; j++) begin : n
                assign i[j] = IDX_W'(j);
            end
        end else begin : lvl
            localparam int NP = cnt(k - 1);
            always_ff @(posedge clk_i) begin
                if (!reset_ni) vld <= 1'b0;
                else if (ready_o) vld <= stg[k-1].vld;
            end
            for (genvar j = 0; j < N; j++) begin : n
                logic [WIDTH-1:0] wv;
                logic [IDX_W-1:0] wi;
                if (2 * j + 1 < NP) begin : c
                    logic lw;
                    assign lw = ge(stg[k-1].v[2*j], stg[k-1].v[2*j+1]);
                    assign wv = lw ? stg[k-1].v[2*j] : stg[k-1].v[2*j+1];
                    assign wi = lw ? stg[k-1].i[2*j] : stg[k-1].i[2*j+1];
                end else begin : p
                    assign wv = stg[k-1].v[2*j];
                    assign wi = stg[k-1].i[2*j];
                end
                always_ff @(posedge clk_i) begin
                    if (!reset_ni) begin
                        v[j] <= '0;
                        i[j] <= '0;
                    end else if (ready_o) begin
                        v[j] <= wv;
                        i[j] <= wi;
                    end
                end
            end
        end
`ifdef MAX_TREE_THRESH_EN
        if (k < LEVELS) begin : th
            logic [WIDTH-1:0] t;
            if (k == 0) begin : s0
                assign t = threshold_i;
            end else begin : sk
                always_ff @(posedge clk_i) begin
                    if (!reset_ni) t <= '0;
                    else if (ready_o) t <= stg[k-1].th.t;
                end
            end
        end else begin : ab
            always_ff @(posedge clk_i) begin
                if (!reset_ni) above_o <= 1'b0;
                else if (ready_o) above_o <= ge(lvl.n[0].wv, stg[k-1].th.t);
            end
        end
`endif
    end

    assign valid_o = stg[LEVELS].vld;
    assign index_o = stg[LEVELS].i[0];
    assign max_o = stg[LEVELS].v[0];
endmodule
